sr_latch_seq: RTL and testbench
===============================

SR_LATCH_SEQ -- requirements
Module: sr_latch_seq

Interface
REQ-001 Parameter N_LATCH, default 4: number of SR latches in the driven bank (2..16).
REQ-002 Parameter HOLD_CYC, default 2: cycles enable stays low after a drive pulse before acknowledge (1..15).
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports a_req / b_req, input, 1 each: command request from requester A / B.
REQ-006 Ports a_set, a_clr / b_set, b_clr, input, 1 each: set and clear intent for the target latch.
REQ-007 Ports a_idx / b_idx, input, $clog2(N_LATCH): target latch index.
REQ-008 Ports a_ack / b_ack, output, 1 each: one-cycle completion pulse to the granted requester.
REQ-009 Port lat_s, output, N_LATCH: set lines to the latch bank.
REQ-010 Port lat_r, output, N_LATCH: reset lines to the latch bank.
REQ-011 Port lat_en, output, 1: shared latch enable.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port err, output, 1: sticky flag for an illegal command (set and clr both high).
REQ-014 Port shadow_q, output, N_LATCH: expected latch contents (see Configuration).

Function
REQ-015 FSM states: IDLE, DRIVE, HOLD, ACK.
REQ-016 IDLE: if any req is high, grant one requester, register its set/clr/idx, and select the next state per REQ-017 to REQ-019.
REQ-017 Arbitration: round-robin; on simultaneous a_req and b_req, the requester not granted last wins; after reset, A has priority.
REQ-018 Legal command (exactly one of set/clr high): IDLE->DRIVE.
REQ-019 No-op (neither set nor clr high) and illegal (both high): IDLE->ACK directly; lat_en stays 0; illegal additionally sets err.
REQ-020 DRIVE (exactly 1 cycle): lat_en=1, lat_s[idx]=set, lat_r[idx]=clr, all other bits 0; DRIVE->HOLD.
REQ-021 HOLD: lat_en=0, lat_s=lat_r=0 for exactly HOLD_CYC cycles; then HOLD->ACK.
REQ-022 ACK (1 cycle): pulse ack of the granted requester only; ACK->IDLE.
REQ-023 lat_s[i] and lat_r[i] shall never both be 1 in any cycle.
REQ-024 lat_s and lat_r shall be 0 whenever lat_en=0.
REQ-025 Latency: with req sampled in IDLE at cycle 0, ack fires at cycle 2+HOLD_CYC for a legal command and at cycle 1 for a no-op or illegal command.
REQ-026 A requester holds req, set, clr and idx stable until it sees ack; the block samples them only in IDLE.
REQ-027 A req still high in the cycle after ack is treated as a new request.
REQ-028 An idx >= N_LATCH is treated as illegal: err is set, no drive occurs, and ack is still pulsed.
REQ-029 All outputs are registered.

Reset
REQ-030 rst in any state (including mid-DRIVE or HOLD) forces IDLE on the next edge.
REQ-031 Reset values: lat_en=0, lat_s=lat_r=0, a_ack=b_ack=0, busy=0, err=0, shadow_q=0, round-robin pointer=A.
REQ-032 An operation interrupted by reset is discarded and never acknowledged.

Configuration
REQ-033 With macro SR_LATCH_SEQ_SHADOW_EN defined, shadow_q[idx] updates in DRIVE: set->1, clr->0.
REQ-034 Without SR_LATCH_SEQ_SHADOW_EN, shadow_q is tied to 0 and no shadow flops are built.

Structure
REQ-035 Package sr_latch_seq_pkg holds the FSM state enum, the command-kind encoding (NOP, SET, CLR, ILLEGAL), and the HOLD counter width constant.
REQ-036 A sub-module sr_seq_rr_arb holds the two-requester round-robin grant and its last-grant pointer.

Verification (N_LATCH=4, HOLD_CYC=2)
REQ-037 a_req, a_set=1, idx=2 -> lat_en=1 with lat_s=4'b0100 one cycle later; a_ack at cycle 4; shadow_q[2]=1 if enabled.
REQ-038 a_req and b_req in the same cycle after reset -> A served first, then B; next simultaneous pair -> B first.
REQ-039 b_req, b_set=1, b_clr=1 -> no lat_en pulse, err=1, b_ack at cycle 1; err remains 1 until rst.
REQ-040 rst asserted during HOLD -> IDLE next cycle, no ack, all outputs at reset values.
REQ-041 a_req, idx=3, neither set nor clr -> ack at cycle 1, lat_en never asserted, err stays 0.
REQ-042 Random legal traffic for 1000 commands -> assertion that S=R=1 never occurs and lat_s/lat_r are 0 whenever lat_en=0 holds throughout.

Source files
------------

// File: rtl/sr_latch_seq_pkg.sv
// Shared types for the SR latch sequencer: FSM states, command kinds and the
// HOLD counter width.
package sr_latch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD,
        ST_ACK
    } state_e;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_SET,
        CMD_CLR,
        CMD_ILLEGAL
    } cmd_kind_e;

    // Wide enough for the largest supported HOLD_CYC (15).
    localparam int HOLD_CNT_W = 4;

    function automatic cmd_kind_e decode_cmd(input logic set_i, input logic clr_i);
        cmd_kind_e kind;
        case ({set_i, clr_i})
            2'b10:   kind = CMD_SET;
            2'b01:   kind = CMD_CLR;
            2'b11:   kind = CMD_ILLEGAL;
            default: kind = CMD_NOP;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/sr_seq_rr_arb.sv
// Two-requester round-robin arbiter; A has priority after reset and the last
// granted requester loses the next tie.
module sr_seq_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic accept_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    logic prio_b_q;
    logic prio_b_d;

    always_comb begin
        grant_a_o = a_req_i && (!b_req_i || !prio_b_q);
        grant_b_o = b_req_i && !grant_a_o;
    end

    // The pointer only moves when the grant is actually taken by the sequencer.
    always_comb begin
        prio_b_d = prio_b_q;
        if (accept_i) begin
            prio_b_d = grant_a_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/sr_latch_seq.sv
// Sequences set/clear commands from two requesters onto a shared SR latch bank.
// Define SR_LATCH_SEQ_SHADOW_EN to build the shadow copy of the latch contents.
module sr_latch_seq
    import sr_latch_seq_pkg::*;
#(
    parameter int N_LATCH  = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_req,
    input  logic                       a_set,
    input  logic                       a_clr,
    input  logic [$clog2(N_LATCH)-1:0] a_idx,
    input  logic                       b_req,
    input  logic                       b_set,
    input  logic                       b_clr,
    input  logic [$clog2(N_LATCH)-1:0] b_idx,
    output logic                       a_ack,
    output logic                       b_ack,
    output logic [N_LATCH-1:0]         lat_s,
    output logic [N_LATCH-1:0]         lat_r,
    output logic                       lat_en,
    output logic                       busy,
    output logic                       err,
    output logic [N_LATCH-1:0]         shadow_q
);

    localparam int IDX_W = $clog2(N_LATCH);
    localparam logic [IDX_W:0] N_LAT_V = (IDX_W + 1)'(N_LATCH);

    state_e                 state_q, state_d;
    cmd_kind_e              kind_q, kind_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   owner_b_q, owner_b_d;
    logic [HOLD_CNT_W-1:0]  cnt_q, cnt_d;

    logic                   lat_en_q, lat_en_d;
    logic [N_LATCH-1:0]     lat_s_q, lat_s_d;
    logic [N_LATCH-1:0]     lat_r_q, lat_r_d;
    logic                   a_ack_q, a_ack_d;
    logic                   b_ack_q, b_ack_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   grant_a;
    logic                   grant_b;
    logic                   sel_set;
    logic                   sel_clr;
    logic [IDX_W-1:0]       sel_idx;
    cmd_kind_e              sel_kind;

    assign accept = (state_q == ST_IDLE) && (a_req || b_req);

    sr_seq_rr_arb u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_req_i   (a_req),
        .b_req_i   (b_req),
        .accept_i  (accept),
        .grant_a_o (grant_a),
        .grant_b_o (grant_b)
    );

    // Out-of-range indices are folded into the illegal kind so they never drive.
    always_comb begin
        sel_set = grant_a ? a_set : b_set;
        sel_clr = grant_a ? a_clr : b_clr;
        sel_idx = grant_a ? a_idx : b_idx;
        if ({1'b0, sel_idx} >= N_LAT_V) begin
            sel_kind = CMD_ILLEGAL;
        end else begin
            sel_kind = decode_cmd(sel_set, sel_clr);
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        idx_d     = idx_q;
        owner_b_d = owner_b_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    kind_d    = sel_kind;
                    idx_d     = sel_idx;
                    owner_b_d = grant_b;
                    if (sel_kind == CMD_SET || sel_kind == CMD_CLR) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_DRIVE: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_CNT_W'(HOLD_CYC - 1);
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - HOLD_CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        lat_en_d = (state_d == ST_DRIVE);
        lat_s_d  = '0;
        lat_r_d  = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (state_d == ST_DRIVE && idx_d == IDX_W'(i)) begin
                lat_s_d[i] = (kind_d == CMD_SET);
                lat_r_d[i] = (kind_d == CMD_CLR);
            end
        end
        a_ack_d = (state_d == ST_ACK) && !owner_b_d;
        b_ack_d = (state_d == ST_ACK) && owner_b_d;
        busy_d  = (state_d != ST_IDLE);
        err_d   = err_q || (accept && sel_kind == CMD_ILLEGAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            kind_q    <= CMD_NOP;
            idx_q     <= '0;
            owner_b_q <= 1'b0;
            cnt_q     <= '0;
            lat_en_q  <= 1'b0;
            lat_s_q   <= '0;
            lat_r_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            idx_q     <= idx_d;
            owner_b_q <= owner_b_d;
            cnt_q     <= cnt_d;
            lat_en_q  <= lat_en_d;
            lat_s_q   <= lat_s_d;
            lat_r_q   <= lat_r_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign lat_en = lat_en_q;
    assign lat_s  = lat_s_q;
    assign lat_r  = lat_r_q;
    assign a_ack  = a_ack_q;
    assign b_ack  = b_ack_q;
    assign busy   = busy_q;
    assign err    = err_q;

`ifdef SR_LATCH_SEQ_SHADOW_EN
    logic [N_LATCH-1:0] shadow_d;

    assign shadow_d = (shadow_q & ~lat_r_d) | lat_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign shadow_q = '0;
`endif

endmodule

// File: tb/tb_sr_latch_seq.sv
// Self-checking bench for sr_latch_seq: directed scenarios plus randomized
// two-requester traffic checked against a transaction-level model.
module tb_sr_latch_seq;

    localparam int N_LATCH  = 4;
    localparam int HOLD_CYC = 2;
    localparam int IDX_W    = $clog2(N_LATCH);
    localparam int VEC_W    = 3 * N_LATCH + 5;

`ifdef SR_LATCH_SEQ_SHADOW_EN
    localparam bit SHADOW_ON = 1'b1;
`else
    localparam bit SHADOW_ON = 1'b0;
`endif

    typedef struct {
        logic               en;
        logic [N_LATCH-1:0] s;
        logic [N_LATCH-1:0] r;
        logic               aa;
        logic               ab;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               a_req, a_set, a_clr;
    logic [IDX_W-1:0]   a_idx;
    logic               b_req, b_set, b_clr;
    logic [IDX_W-1:0]   b_idx;
    logic               a_ack, b_ack;
    logic [N_LATCH-1:0] lat_s, lat_r;
    logic               lat_en, busy, err;
    logic [N_LATCH-1:0] shadow_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sr_latch_seq #(.N_LATCH(N_LATCH), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_set(a_set), .a_clr(a_clr), .a_idx(a_idx),
        .b_req(b_req), .b_set(b_set), .b_clr(b_clr), .b_idx(b_idx),
        .a_ack(a_ack), .b_ack(b_ack),
        .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en),
        .busy(busy), .err(err), .shadow_q(shadow_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req = 1'b0; a_set = 1'b0; a_clr = 1'b0; a_idx = '0;
        b_req = 1'b0; b_set = 1'b0; b_clr = 1'b0; b_idx = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic new_cmd(input bit legal_only, output logic s, output logic c,
                           output logic [IDX_W-1:0] i);
        int k;
        k = legal_only ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 3));
        s = (k == 1 || k == 3);
        c = (k == 2 || k == 3);
        i = IDX_W'($urandom_range(0, N_LATCH - 1));
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        total++; if (lat_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_lat_en got=%b want=0", lat_en); end
        total++; if (lat_s !== '0) begin bad++; $display("[TB] FAIL reset_lat_s got=%b want=0", lat_s); end
        total++; if (lat_r !== '0) begin bad++; $display("[TB] FAIL reset_lat_r got=%b want=0", lat_r); end
        total++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("[TB] FAIL reset_acks got=%b want=00", {a_ack, b_ack}); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err); end
        total++; if (shadow_q !== '0) begin bad++; $display("[TB] FAIL reset_shadow got=%b want=0", shadow_q); end
        rst = 1'b0;
    endtask

    task automatic test_legal_drive();
        int ack_cyc;
        int stray;
        int n;
        do_reset();
        a_req = 1'b1; a_set = 1'b1; a_idx = 2'd2;
        tick();
        total++; if ({lat_en, lat_s, lat_r} !== {1'b1, 4'b0100, 4'b0000})
            begin bad++; $display("[TB] FAIL set_drive got en=%b s=%b r=%b want en=1 s=0100 r=0000", lat_en, lat_s, lat_r); end
        total++; if (shadow_q !== (SHADOW_ON ? 4'b0100 : 4'b0000))
            begin bad++; $display("[TB] FAIL set_shadow got=%b want=%b", shadow_q, SHADOW_ON ? 4'b0100 : 4'b0000); end
        ack_cyc = -1;
        stray   = 0;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (lat_en !== 1'b0 || lat_s !== '0 || lat_r !== '0) stray++;
            if (a_ack === 1'b1) begin
                ack_cyc = c;
                break;
            end
        end
        total++; if (ack_cyc != 2 + HOLD_CYC) begin bad++; $display("[TB] FAIL set_ack_cycle got=%0d want=%0d", ack_cyc, 2 + HOLD_CYC); end
        total++; if (stray != 0) begin bad++; $display("[TB] FAIL set_hold_quiet got=%0d noisy cycles want=0", stray); end
        total++; if (b_ack !== 1'b0) begin bad++; $display("[TB] FAIL set_wrong_ack got b_ack=%b want=0", b_ack); end
        clear_inputs();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
        a_req = 1'b1; a_clr = 1'b1; a_idx = 2'd2;
        tick();
        total++; if ({lat_en, lat_s, lat_r} !== {1'b1, 4'b0000, 4'b0100})
            begin bad++; $display("[TB] FAIL clr_drive got en=%b s=%b r=%b want en=1 s=0000 r=0100", lat_en, lat_s, lat_r); end
        total++; if (shadow_q !== 4'b0000) begin bad++; $display("[TB] FAIL clr_shadow got=%b want=0000", shadow_q); end
        wait_ack(n);
        total++; if (n != 1 + HOLD_CYC) begin bad++; $display("[TB] FAIL clr_ack_cycle got=%0d want=%0d", n + 1, 2 + HOLD_CYC); end
        clear_inputs();
    endtask

    task automatic test_arbitration();
        int  n_acks;
        int  n_drv;
        logic [2:0] order;
        logic [2*N_LATCH-1:0] drv [2];
        do_reset();
        a_req = 1'b1; a_set = 1'b1; a_idx = 2'd0;
        b_req = 1'b1; b_clr = 1'b1; b_idx = 2'd1;
        n_acks = 0;
        n_drv  = 0;
        order  = '0;
        drv[0] = '0;
        drv[1] = '0;
        for (int c = 1; c <= 40 && n_acks < 3; c++) begin
            tick();
            if (lat_en === 1'b1 && n_drv < 2) begin
                drv[n_drv] = {lat_s, lat_r};
                n_drv++;
            end
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                order[2 - n_acks] = b_ack;
                n_acks++;
            end
        end
        total++; if (n_acks != 3) begin bad++; $display("[TB] FAIL arb_ack_count got=%0d want=3", n_acks); end
        total++; if (order !== 3'b010) begin bad++; $display("[TB] FAIL arb_order got=%b want=010 (0=A,1=B)", order); end
        total++; if (drv[0] !== {4'b0001, 4'b0000}) begin bad++; $display("[TB] FAIL arb_first_drive got=%b want=00010000", drv[0]); end
        total++; if (drv[1] !== {4'b0000, 4'b0010}) begin bad++; $display("[TB] FAIL arb_second_drive got=%b want=00000010", drv[1]); end
        clear_inputs();
    endtask

    task automatic test_illegal();
        int en_seen;
        int err_low;
        int n;
        do_reset();
        b_req = 1'b1; b_set = 1'b1; b_clr = 1'b1; b_idx = 2'd1;
        tick();
        total++; if ({a_ack, b_ack} !== 2'b01) begin bad++; $display("[TB] FAIL ill_ack got a=%b b=%b want a=0 b=1", a_ack, b_ack); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL ill_err got=%b want=1", err); end
        en_seen = (lat_en !== 1'b0) ? 1 : 0;
        err_low = 0;
        clear_inputs();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (lat_en !== 1'b0) en_seen++;
            if (err !== 1'b1) err_low++;
        end
        total++; if (en_seen != 0) begin bad++; $display("[TB] FAIL ill_no_drive got=%0d enable cycles want=0", en_seen); end
        total++; if (err_low != 0) begin bad++; $display("[TB] FAIL ill_err_sticky got=%0d low cycles want=0", err_low); end
        a_req = 1'b1; a_set = 1'b1; a_idx = 2'd0;
        wait_ack(n);
        total++; if (n != 2 + HOLD_CYC) begin bad++; $display("[TB] FAIL ill_then_legal_ack got=%0d want=%0d", n, 2 + HOLD_CYC); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL ill_err_kept got=%b want=1", err); end
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL ill_err_cleared got=%b want=0", err); end
    endtask

    task automatic test_nop();
        int en_seen;
        do_reset();
        a_req = 1'b1; a_idx = 2'd3;
        tick();
        total++; if ({a_ack, b_ack, busy} !== 3'b101) begin bad++; $display("[TB] FAIL nop_ack got a=%b b=%b busy=%b want 1 0 1", a_ack, b_ack, busy); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL nop_err got=%b want=0", err); end
        en_seen = (lat_en !== 1'b0) ? 1 : 0;
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            tick();
            if (lat_en !== 1'b0 || err !== 1'b0) en_seen++;
        end
        total++; if (en_seen != 0) begin bad++; $display("[TB] FAIL nop_quiet got=%0d bad cycles want=0", en_seen); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL nop_idle got busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_hold();
        int acks;
        int n;
        logic [VEC_W-1:0] got_v;
        do_reset();
        a_req = 1'b1; a_set = 1'b1; a_idx = 2'd1;
        tick();
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got_v = {busy, lat_en, lat_s, lat_r, a_ack, b_ack, err, shadow_q};
        total++; if (got_v !== '0) begin bad++; $display("[TB] FAIL hold_reset_outputs got=%b want=0", got_v); end
        acks = 0;
        for (int c = 0; c < 2 * HOLD_CYC + 4; c++) begin
            tick();
            if (a_ack !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b0) acks++;
        end
        total++; if (acks != 0) begin bad++; $display("[TB] FAIL hold_reset_discard got=%0d active cycles want=0", acks); end
        a_req = 1'b1; a_set = 1'b1; a_idx = 2'd0;
        b_req = 1'b1; b_set = 1'b1; b_idx = 2'd3;
        wait_ack(n);
        total++; if (n != 2 + HOLD_CYC || {a_ack, b_ack} !== 2'b10)
            begin bad++; $display("[TB] FAIL hold_reset_pointer got cycle=%0d a=%b b=%b want cycle=%0d a=1 b=0", n, a_ack, b_ack, 2 + HOLD_CYC); end
        clear_inputs();
    endtask

    task automatic test_random(input int n_cmds, input bit legal_only);
        exp_t               q[$];
        exp_t               e;
        exp_t               zero_e;
        bit                 a_pend, b_pend, m_err, cur_idle, exp_busy;
        int                 last_win, win, done, cyc;
        logic               set_v, clr_v;
        logic [IDX_W-1:0]   idx_v;
        logic [N_LATCH-1:0] m_shadow, one_hot, exp_sh;
        logic [VEC_W-1:0]   exp_v, got_v;
        do_reset();
        zero_e   = '{en: 1'b0, s: '0, r: '0, aa: 1'b0, ab: 1'b0};
        a_pend   = 1'b0;
        b_pend   = 1'b0;
        m_err    = 1'b0;
        cur_idle = 1'b1;
        last_win = 1;
        done     = 0;
        cyc      = 0;
        m_shadow = '0;
        while (done < n_cmds && cyc < 20000) begin
            if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1'b1;
                new_cmd(legal_only, a_set, a_clr, a_idx);
            end
            if (!b_pend && $urandom_range(0, 1) == 1) begin
                b_pend = 1'b1;
                new_cmd(legal_only, b_set, b_clr, b_idx);
            end
            a_req = a_pend;
            b_req = b_pend;
            if (cur_idle && (a_pend || b_pend)) begin
                win = (a_pend && b_pend) ? 1 - last_win : (a_pend ? 0 : 1);
                last_win = win;
                set_v = (win == 1) ? b_set : a_set;
                clr_v = (win == 1) ? b_clr : a_clr;
                idx_v = (win == 1) ? b_idx : a_idx;
                if (set_v != clr_v) begin
                    one_hot = '0;
                    one_hot[idx_v] = 1'b1;
                    e = zero_e;
                    e.en = 1'b1;
                    e.s  = set_v ? one_hot : '0;
                    e.r  = clr_v ? one_hot : '0;
                    q.push_back(e);
                    for (int h = 0; h < HOLD_CYC; h++) q.push_back(zero_e);
                    m_shadow[idx_v] = set_v;
                end else if (set_v && clr_v) begin
                    m_err = 1'b1;
                end
                e = zero_e;
                e.aa = (win == 0);
                e.ab = (win == 1);
                q.push_back(e);
            end
            tick();
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_busy = 1'b1;
                cur_idle = 1'b0;
            end else begin
                e = zero_e;
                exp_busy = 1'b0;
                cur_idle = 1'b1;
            end
            exp_sh = SHADOW_ON ? m_shadow : '0;
            exp_v  = {exp_busy, e.en, e.s, e.r, e.aa, e.ab, m_err, exp_sh};
            got_v  = {busy, lat_en, lat_s, lat_r, a_ack, b_ack, err, shadow_q};
            total++; if (got_v !== exp_v)
                begin bad++; $display("[TB] FAIL random_cycle %0d got=%b want=%b (busy,en,s,r,aa,ab,err,shadow)", cyc, got_v, exp_v); end
            total++; if ((lat_s & lat_r) !== '0 || (lat_en !== 1'b1 && (lat_s | lat_r) !== '0))
                begin bad++; $display("[TB] FAIL random_sr_invariant cycle %0d got en=%b s=%b r=%b", cyc, lat_en, lat_s, lat_r); end
            if (e.aa) begin a_pend = 1'b0; done++; a_req = 1'b0; end
            if (e.ab) begin b_pend = 1'b0; done++; b_req = 1'b0; end
        end
        total++; if (done < n_cmds) begin bad++; $display("[TB] FAIL random_progress got=%0d commands want=%0d", done, n_cmds); end
        clear_inputs();
    endtask

    initial begin
        #400000;
        bad++;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_legal_drive();
        test_arbitration();
        test_illegal();
        test_nop();
        test_reset_mid_hold();
        test_random(1000, 1'b1);
        test_random(300, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
